// File: rtl/irq_pkg.sv
// Shared constants, FSM state type and group-priority helper for the interrupt controller.
package irq_pkg;

  localparam int NUM_SRC    = 16;
  localparam int GROUP_SIZE = 4;

  localparam logic [2:0] OFF_PRIO      = 3'd0;
  localparam logic [2:0] OFF_ENABLE_LO = 3'd1;
  localparam logic [2:0] OFF_ENABLE_HI = 3'd2;
  localparam logic [2:0] OFF_FLAG_LO   = 3'd3;
  localparam logic [2:0] OFF_FLAG_HI   = 3'd4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REQUEST    = 2'd1,
    WAIT_CLEAR = 2'd2
  } irq_state_t;

  // Priority of the group that owns source idx (groups are idx[3:2]).
  function automatic logic [1:0] group_prio(input logic [7:0] prio, input logic [3:0] idx);
    return prio[{idx[3:2], 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/irq_arbiter.sv
// Combinational arbiter: highest group priority wins, ties resolved toward the lowest index.
module irq_arbiter
  import irq_pkg::*;
(
  input  logic [15:0] flag,
  input  logic [15:0] enable,
  input  logic [7:0]  prio,
  output logic        win_valid,
  output logic [3:0]  win_index,
  output logic [1:0]  win_level
);

  logic [1:0] lvl;

  always_comb begin
    win_valid = 1'b0;
    win_index = 4'd0;
    win_level = 2'd0;
    lvl       = 2'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      lvl = group_prio(prio, 4'(i));
      // Strictly-greater keeps the earlier (lower) index on equal levels.
      if (flag[i] && enable[i] && (lvl != 2'd0) && (!win_valid || (lvl > win_level))) begin
        win_valid = 1'b1;
        win_index = 4'(i);
        win_level = lvl;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge-detected flags, bus-mapped enable/priority, and a CPU request/ack FSM.
module irq_controller
  import irq_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR = 24'h2020,
  parameter int          NUM_SRC   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clk_ce,
  input  logic               bus_write,
  input  logic               bus_read,
  input  logic [23:0]        bus_address_in,
  input  logic [7:0]         bus_data_in,
  output logic [7:0]         bus_data_out,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [1:0]         cpu_ilevel,
  output logic               irq_req,
  output logic [3:0]         irq_vector,
  output logic [1:0]         irq_level,
  input  logic               irq_ack,
  output irq_state_t         dbg_state
);

  logic [7:0]  prio_q, prio_d;
  logic [15:0] enable_q, enable_d;
  logic [15:0] flag_q, flag_d;
  logic [15:0] prev_q, prev_d;
  logic [15:0] flag_clr;
  logic [3:0]  vec_q, vec_d;
  logic [1:0]  lvl_q, lvl_d;
  irq_state_t  state_q, state_d;

  logic [23:0] offset;
  logic        hit;
  logic [2:0]  reg_sel;
  logic        wr_en;
  logic        win_valid;
  logic [3:0]  win_index;
  logic [1:0]  win_level;
  logic        latched_ok;

  // Reads have no side effects, so the strobe is not needed for decode.
  wire unused_bus_read = bus_read;

  assign offset  = bus_address_in - BASE_ADDR;
  assign hit     = (offset < 24'd5);
  assign reg_sel = offset[2:0];
  assign wr_en   = bus_write && hit;

  always_comb begin
    prio_d   = prio_q;
    enable_d = enable_q;
    flag_clr = 16'h0000;
    if (wr_en) begin
      case (reg_sel)
        OFF_PRIO:      prio_d         = bus_data_in;
        OFF_ENABLE_LO: enable_d[7:0]  = bus_data_in;
        OFF_ENABLE_HI: enable_d[15:8] = bus_data_in;
        OFF_FLAG_LO:   flag_clr[7:0]  = bus_data_in;
        OFF_FLAG_HI:   flag_clr[15:8] = bus_data_in;
        default: ;
      endcase
    end
    // New edges are OR-ed in after the clear so a simultaneous event survives.
    flag_d = (flag_q & ~flag_clr) | (irq_src & ~prev_q);
    prev_d = irq_src;
  end

  always_comb begin
    bus_data_out = 8'h00;
    if (hit) begin
      case (reg_sel)
        OFF_PRIO:      bus_data_out = prio_q;
        OFF_ENABLE_LO: bus_data_out = enable_q[7:0];
        OFF_ENABLE_HI: bus_data_out = enable_q[15:8];
        OFF_FLAG_LO:   bus_data_out = flag_q[7:0];
        OFF_FLAG_HI:   bus_data_out = flag_q[15:8];
        default:       bus_data_out = 8'h00;
      endcase
    end
  end

  irq_arbiter u_arbiter (
    .flag      (flag_q),
    .enable    (enable_q),
    .prio      (prio_q),
    .win_valid (win_valid),
    .win_index (win_index),
    .win_level (win_level)
  );

  assign latched_ok = flag_q[vec_q] && enable_q[vec_q] &&
                      (group_prio(prio_q, vec_q) != 2'd0) && (lvl_q > cpu_ilevel);

  // Handshake: irq_req is high exactly in REQUEST; vector/level are frozen there,
  // and an irq_ack sampled on a CE edge in REQUEST completes the transfer.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    lvl_d   = lvl_q;
    case (state_q)
      IDLE: begin
        if (win_valid && (win_level > cpu_ilevel)) begin
          vec_d   = win_index;
          lvl_d   = win_level;
          state_d = REQUEST;
        end
      end
      REQUEST: begin
        if (irq_ack)          state_d = WAIT_CLEAR;
        else if (!latched_ok) state_d = IDLE;
      end
      WAIT_CLEAR: begin
        if (!flag_q[vec_q] || !enable_q[vec_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q   <= 8'h00;
      enable_q <= 16'h0000;
      flag_q   <= 16'h0000;
      prev_q   <= 16'h0000;
      vec_q    <= 4'd0;
      lvl_q    <= 2'd0;
      state_q  <= IDLE;
    end else if (clk_ce) begin
      prio_q   <= prio_d;
      enable_q <= enable_d;
      flag_q   <= flag_d;
      prev_q   <= prev_d;
      vec_q    <= vec_d;
      lvl_q    <= lvl_d;
      state_q  <= state_d;
    end
  end

  assign irq_req    = (state_q == REQUEST);
  assign irq_vector = vec_q;
  assign irq_level  = lvl_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: expected values queued at stimulus time, popped at observation.
module tb_irq_controller;
  import irq_pkg::*;

  localparam logic [23:0] BASE = 24'h2020;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_ce = 1'b1;
  logic        bus_write = 1'b0;
  logic        bus_read = 1'b0;
  logic [23:0] bus_address_in = 24'h0;
  logic [7:0]  bus_data_in = 8'h0;
  logic [7:0]  bus_data_out;
  logic [15:0] irq_src = 16'h0;
  logic [1:0]  cpu_ilevel = 2'd0;
  logic        irq_req;
  logic [3:0]  irq_vector;
  logic [1:0]  irq_level;
  logic        irq_ack = 1'b0;
  irq_state_t  dbg_state;

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  irq_controller #(.BASE_ADDR(BASE), .NUM_SRC(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .clk_ce         (clk_ce),
    .bus_write      (bus_write),
    .bus_read       (bus_read),
    .bus_address_in (bus_address_in),
    .bus_data_in    (bus_data_in),
    .bus_data_out   (bus_data_out),
    .irq_src        (irq_src),
    .cpu_ilevel     (cpu_ilevel),
    .irq_req        (irq_req),
    .irq_vector     (irq_vector),
    .irq_level      (irq_level),
    .irq_ack        (irq_ack),
    .dbg_state      (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string tag, input logic [7:0] obs);
    logic [7:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty observed=%h", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  task automatic bus_wr(input logic [2:0] off, input logic [7:0] data);
    bus_address_in = BASE + 24'(off);
    bus_data_in    = data;
    bus_write      = 1'b1;
    cyc();
    bus_write      = 1'b0;
    bus_address_in = 24'h0;
  endtask

  task automatic expect_rd(input string tag, input logic [2:0] off, input logic [7:0] exp);
    exp_q.push_back(exp);
    bus_address_in = BASE + 24'(off);
    bus_read       = 1'b1;
    #1;
    compare(tag, bus_data_out);
    bus_read       = 1'b0;
    bus_address_in = 24'h0;
  endtask

  task automatic expect_irq(input string tag, input logic req, input logic [3:0] vec,
                            input logic [1:0] lvl);
    exp_q.push_back({1'b0, req, vec, lvl});
    compare(tag, {1'b0, irq_req, irq_vector, irq_level});
  endtask

  task automatic expect_state(input string tag, input irq_state_t st);
    exp_q.push_back({6'd0, st});
    compare(tag, {6'd0, dbg_state});
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc();
    expect_rd("rst_prio", OFF_PRIO, 8'h00);
    expect_rd("rst_en_lo", OFF_ENABLE_LO, 8'h00);
    expect_rd("rst_en_hi", OFF_ENABLE_HI, 8'h00);
    expect_rd("rst_flag_lo", OFF_FLAG_LO, 8'h00);
    expect_rd("rst_flag_hi", OFF_FLAG_HI, 8'h00);
    expect_irq("rst_irq", 1'b0, 4'd0, 2'd0);
    expect_state("rst_state", IDLE);

    // Single source 4, group 1 priority 1
    bus_wr(OFF_PRIO, 8'h04);
    bus_wr(OFF_ENABLE_LO, 8'h10);
    expect_rd("prio_rd", OFF_PRIO, 8'h04);
    irq_src = 16'h0010;
    cyc();
    irq_src = 16'h0000;
    expect_rd("t1_flag", OFF_FLAG_LO, 8'h10);
    expect_irq("t1_n1", 1'b0, 4'd0, 2'd0);
    cyc();
    expect_irq("t1_n2", 1'b1, 4'd4, 2'd1);
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    expect_irq("t1_ack", 1'b0, 4'd4, 2'd1);
    expect_state("t1_wait", WAIT_CLEAR);
    bus_wr(OFF_FLAG_LO, 8'h10);
    expect_state("t1_w1", WAIT_CLEAR);
    expect_rd("t1_flag_clr", OFF_FLAG_LO, 8'h00);
    cyc();
    expect_state("t1_idle", IDLE);
    repeat (3) cyc();
    expect_irq("t1_norereq", 1'b0, 4'd4, 2'd1);

    // Priority ordering: g0=1, g1=1, g2=2, g3=3
    bus_wr(OFF_PRIO, 8'hE5);
    bus_wr(OFF_ENABLE_LO, 8'h12);
    bus_wr(OFF_ENABLE_HI, 8'h23);
    irq_src = 16'h2002;
    cyc();
    irq_src = 16'h0000;
    cyc();
    expect_irq("t2_src13", 1'b1, 4'd13, 2'd3);
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    bus_wr(OFF_FLAG_HI, 8'h20);
    cyc();
    expect_state("t2_idle", IDLE);
    cyc();
    expect_irq("t2_src1", 1'b1, 4'd1, 2'd1);
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    bus_wr(OFF_FLAG_LO, 8'h02);
    cyc();
    irq_src = 16'h0300;
    cyc();
    irq_src = 16'h0000;
    cyc();
    expect_irq("t2_tie", 1'b1, 4'd8, 2'd2);

    // Withdraw when the mask level rises, then re-request
    cpu_ilevel = 2'd2;
    cyc();
    expect_irq("t3_withdraw", 1'b0, 4'd8, 2'd2);
    expect_state("t3_idle", IDLE);
    expect_rd("t3_flag", OFF_FLAG_HI, 8'h03);
    cpu_ilevel = 2'd1;
    cyc();
    expect_irq("t3_return", 1'b1, 4'd8, 2'd2);
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    bus_wr(OFF_FLAG_HI, 8'h03);
    cyc();
    expect_state("t3_done", IDLE);
    cpu_ilevel = 2'd0;

    // Set beats clear; a held level is one event
    irq_src = 16'h0004;
    bus_wr(OFF_FLAG_LO, 8'h04);
    expect_rd("t4_set_wins", OFF_FLAG_LO, 8'h04);
    expect_irq("t4_not_enabled", 1'b0, 4'd8, 2'd2);
    bus_wr(OFF_FLAG_LO, 8'h04);
    repeat (10) cyc();
    expect_rd("t4_level_once", OFF_FLAG_LO, 8'h00);
    irq_src = 16'h0000;
    cyc();

    // Asynchronous reset during REQUEST
    irq_src = 16'h0010;
    cyc();
    irq_src = 16'h0000;
    cyc();
    expect_irq("t5_req", 1'b1, 4'd4, 2'd1);
    reset_n = 1'b0;
    #1;
    expect_irq("t5_rst_irq", 1'b0, 4'd0, 2'd0);
    expect_state("t5_rst_state", IDLE);
    expect_rd("t5_prio", OFF_PRIO, 8'h00);
    expect_rd("t5_en_lo", OFF_ENABLE_LO, 8'h00);
    expect_rd("t5_en_hi", OFF_ENABLE_HI, 8'h00);
    expect_rd("t5_flag_lo", OFF_FLAG_LO, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    cyc();

    // Clock enable low holds the edge detector
    bus_wr(OFF_PRIO, 8'h04);
    bus_wr(OFF_ENABLE_LO, 8'h10);
    clk_ce  = 1'b0;
    irq_src = 16'h0010;
    repeat (3) cyc();
    expect_rd("t6_ce_hold", OFF_FLAG_LO, 8'h00);
    expect_irq("t6_ce_noreq", 1'b0, 4'd0, 2'd0);
    clk_ce = 1'b1;
    cyc();
    expect_rd("t6_ce_flag", OFF_FLAG_LO, 8'h10);
    cyc();
    expect_irq("t6_ce_req", 1'b1, 4'd4, 2'd1);
    expect_rd("unmapped", 3'd5, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
